// File: rtl/satalnk_pkg.sv
// rtl/satalnk_pkg.sv - shared SATA link-layer primitives, scrambler/CRC constants and state encoding
package satalnk_pkg;

    // 33-bit primitives: {K flag, dword}, byte 0 (the K character) in bits [31:24]
    localparam logic [32:0] PRIM_SOF   = 33'h17cb53737;
    localparam logic [32:0] PRIM_EOF   = 33'h17cb5d5d5;
    localparam logic [32:0] PRIM_HOLD  = 33'h17caad5d5;
    localparam logic [32:0] PRIM_HOLDA = 33'h17caa9595;
    localparam logic [32:0] PRIM_SYNC  = 33'h17c95b5b5;
    localparam logic [32:0] PRIM_ALIGN = 33'h1bc4a4a7b;
    localparam logic [32:0] PRIM_CONT  = 33'h17caa9999;

    // Scrambler: x^16 + x^15 + x^13 + x^4 + 1, reseeded at every SOF
    localparam logic [15:0] SCR_SEED_DEFAULT = 16'hffff;
    localparam logic [15:0] SCR_POLY_DEFAULT = 16'ha011;

    // Frame CRC: CRC-32 polynomial with the SATA seed
    localparam logic [31:0] CRC_SEED_DEFAULT = 32'h52325032;
    localparam logic [31:0] CRC_POLY_DEFAULT = 32'h04c11db7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_EOF  = 3'd4
    } txf_state_t;

    // Reverse the byte order of a dword
    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/satalnk_scrambler.sv
// rtl/satalnk_scrambler.sv - 16-bit Galois LFSR scrambler producing one 32-bit mask per dword
module satalnk_scrambler
    import satalnk_pkg::*;
#(
    parameter bit          OPT_LITTLE_ENDIAN = 1'b0,
    parameter logic [15:0] INITIAL_SCRAMBLER = SCR_SEED_DEFAULT,
    parameter logic [15:0] SCRAMBLER_POLY    = SCR_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reload,
    input  logic        advance,
    output logic [31:0] mask
);

    logic [15:0] fill;
    logic [15:0] fill_walk;
    logic [31:0] serial_bits;

    // Walk the LFSR 32 steps: emitted bits form this dword's mask, end state is the next fill
    always_comb begin
        fill_walk   = fill;
        serial_bits = '0;
        for (int i = 0; i < 32; i++) begin
            serial_bits[i] = fill_walk[15];
            fill_walk      = {fill_walk[14:0], 1'b0} ^ (fill_walk[15] ? SCRAMBLER_POLY : 16'h0000);
        end
    end

    // Bit 0 is the first serial output; big-endian byte order puts that byte in [31:24]
    assign mask = OPT_LITTLE_ENDIAN ? serial_bits : byte_swap32(serial_bits);

    // LFSR state: seeded on reset and reload, steps a whole dword on advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill <= INITIAL_SCRAMBLER;
        end else if (reload) begin
            fill <= INITIAL_SCRAMBLER;
        end else if (advance) begin
            fill <= fill_walk;
        end
    end

endmodule

// File: rtl/satalnk_txframe.sv
// rtl/satalnk_txframe.sv - SATA link TX framer (SOF, scrambled payload, scrambled CRC, EOF); SATALNK_TXHOLD_EN enables HOLDA on peer HOLD
module satalnk_txframe
    import satalnk_pkg::*;
#(
    parameter bit          OPT_LITTLE_ENDIAN = 1'b0,
    parameter logic [15:0] INITIAL_SCRAMBLER = SCR_SEED_DEFAULT,
    parameter logic [15:0] SCRAMBLER_POLY    = SCR_POLY_DEFAULT,
    parameter logic [31:0] INITIAL_CRC       = CRC_SEED_DEFAULT,
    parameter logic [31:0] CRC_POLY          = CRC_POLY_DEFAULT,
    parameter logic [32:0] P_SOF             = PRIM_SOF,
    parameter logic [32:0] P_EOF             = PRIM_EOF,
    parameter logic [32:0] P_HOLD            = PRIM_HOLD,
    parameter logic [32:0] P_HOLDA           = PRIM_HOLDA,
    parameter logic [32:0] P_SYNC            = PRIM_SYNC
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [32:0] i_idle_prim,
    input  logic        i_remote_hold,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic        i_dn_ready,
    output logic [32:0] o_data,
    output logic        o_busy,
    output logic        o_done
);

    txf_state_t  state;
    txf_state_t  state_next;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [31:0] scr_mask;
    logic [32:0] data_next;
    logic        scr_advance;
    logic        scr_reload;
    logic        done_next;
    logic        hold_active;
    logic        abort_now;
    logic        transfer;

    // MSB-first CRC-32 over one dword, no reflection and no final inversion
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

`ifdef SATALNK_TXHOLD_EN
    assign hold_active = i_remote_hold;
`else
    logic unused_remote_hold;
    assign unused_remote_hold = i_remote_hold;
    assign hold_active        = 1'b0;
`endif

    // Abort only matters once a frame is under way
    assign abort_now = i_abort && (state != ST_IDLE);

    // Payload is taken only in DATA when the link is moving, not held by the peer, and not aborting
    assign s_ready  = i_dn_ready && (state == ST_DATA) && !hold_active && !i_abort;
    assign transfer = s_valid && s_ready;
    assign o_busy   = (state != ST_IDLE);

    satalnk_scrambler #(
        .OPT_LITTLE_ENDIAN (OPT_LITTLE_ENDIAN),
        .INITIAL_SCRAMBLER (INITIAL_SCRAMBLER),
        .SCRAMBLER_POLY    (SCRAMBLER_POLY)
    ) u_scrambler (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .reload  (scr_reload),
        .advance (scr_advance),
        .mask    (scr_mask)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: the frame only moves when the ALIGN stage takes a word
    always_comb begin
        state_next = state;
        if (i_dn_ready) begin
            if (abort_now) begin
                state_next = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (i_start) state_next = ST_SOF;
                    ST_SOF:  state_next = ST_DATA;
                    ST_DATA: if (transfer && s_last) state_next = ST_CRC;
                    ST_CRC:  state_next = ST_EOF;
                    ST_EOF:  state_next = ST_IDLE;
                    default: state_next = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs: next word to the ALIGN stage plus scrambler/CRC control
    always_comb begin
        data_next   = o_data;
        crc_next    = crc;
        scr_advance = 1'b0;
        scr_reload  = 1'b0;
        done_next   = 1'b0;
        if (i_dn_ready) begin
            if (abort_now) begin
                data_next = P_SYNC;
            end else begin
                case (state)
                    ST_IDLE: begin
                        data_next = i_idle_prim;
                        if (i_start) begin
                            scr_reload = 1'b1;
                            crc_next   = INITIAL_CRC;
                        end
                    end
                    ST_SOF: begin
                        data_next = P_SOF;
                    end
                    ST_DATA: begin
                        if (hold_active) begin
                            data_next = P_HOLDA;
                        end else if (!s_valid) begin
                            data_next = P_HOLD;
                        end else begin
                            data_next   = {1'b0, s_data ^ scr_mask};
                            crc_next    = crc_step(crc, s_data);
                            scr_advance = 1'b1;
                        end
                    end
                    ST_CRC: begin
                        data_next   = {1'b0, crc ^ scr_mask};
                        scr_advance = 1'b1;
                    end
                    ST_EOF: begin
                        data_next = P_EOF;
                        done_next = 1'b1;
                    end
                    default: begin
                        data_next = P_SYNC;
                    end
                endcase
            end
        end
    end

    // Output word, running CRC and completion pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data <= P_SYNC;
            crc    <= INITIAL_CRC;
            o_done <= 1'b0;
        end else begin
            o_data <= data_next;
            crc    <= crc_next;
            o_done <= done_next;
        end
    end

endmodule

// File: tb/tb_satalnk_txframe.sv
// tb/tb_satalnk_txframe.sv - directed self-checking bench for satalnk_txframe
module tb_satalnk_txframe;

    localparam logic [32:0] P_SOF   = 33'h17cb53737;
    localparam logic [32:0] P_EOF   = 33'h17cb5d5d5;
    localparam logic [32:0] P_HOLD  = 33'h17caad5d5;
    localparam logic [32:0] P_HOLDA = 33'h17caa9595;
    localparam logic [32:0] P_SYNC  = 33'h17c95b5b5;
    localparam logic [32:0] IDLE_A  = 33'h17c555757;
    localparam logic [32:0] ZERO_W0 = 33'h08d76d2c2;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start;
    logic        i_abort;
    logic [32:0] i_idle_prim;
    logic        i_remote_hold;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic        i_dn_ready;
    logic [32:0] o_data;
    logic        o_busy;
    logic        o_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] pay [0:7];
    logic [32:0] cap_q [$];
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];
    logic [32:0] ref_q [$];
    int          done_total = 0;
    int          hold_cnt;
    int          holda_cnt;
    int          after_idx;
    int          accepted;
    bit          sready_in_stall;
    bit          data_moved;
    logic        last_rdy;

    satalnk_txframe dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_idle_prim   (i_idle_prim),
        .i_remote_hold (i_remote_hold),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .i_dn_ready    (i_dn_ready),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Record every word the ALIGN stage actually took
    always @(posedge i_clk) last_rdy <= i_dn_ready;
    always @(negedge i_clk) begin
        if (last_rdy === 1'b1) cap_q.push_back(o_data);
        if (o_done === 1'b1) done_total++;
    end

    // Reference scrambler: serial Galois LFSR, k-th dword mask after the seed, big-endian bytes
    function automatic logic [31:0] model_mask(input int k);
        logic [15:0] s;
        logic [31:0] r;
        s = 16'hffff;
        r = '0;
        for (int w = 0; w <= k; w++) begin
            for (int i = 0; i < 32; i++) begin
                r[i] = s[15];
                s = {s[14:0], 1'b0} ^ (r[i] ? 16'ha011 : 16'h0000);
            end
        end
        return {r[7:0], r[15:8], r[23:16], r[31:24]};
    endfunction

    // Reference CRC: one data bit at a time, MSB first
    function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [31:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = c << 1;
            if (fb) c = c ^ 32'h04c11db7;
        end
        return c;
    endfunction

    task automatic build_expected(input int n);
        logic [31:0] c;
        c = 32'h52325032;
        exp_q.delete();
        exp_q.push_back(P_SOF);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b0, pay[k] ^ model_mask(k)});
            c = model_crc(c, pay[k]);
        end
        exp_q.push_back({1'b0, c ^ model_mask(n)});
        exp_q.push_back(P_EOF);
    endtask

    // Pull the frame out of the capture log, setting HOLD/HOLDA aside
    task automatic extract(input int base, input int nwords);
        int i;
        got_q.delete();
        hold_cnt  = 0;
        holda_cnt = 0;
        i = base;
        while (i < cap_q.size() && cap_q[i] !== P_SOF) i++;
        while (i < cap_q.size() && got_q.size() < nwords) begin
            if (cap_q[i] === P_HOLD) hold_cnt++;
            else if (cap_q[i] === P_HOLDA) holda_cnt++;
            else got_q.push_back(cap_q[i]);
            i++;
        end
        after_idx = i;
    endtask

    // Upstream source: start a frame, feed pay[0..n-1] with optional gap, stall, peer hold or abort
    task automatic drive_frame(input int n, input int gap_after, input int gap_len,
                               input int rdy_at, input int rdy_len,
                               input int hold_at, input int hold_len, input int abort_at);
        int          idx;
        int          gap;
        int          cyc;
        bit          aborted;
        bit          fin;
        bit          in_stall;
        logic [32:0] held;
        idx = 0; gap = 0; cyc = 0; aborted = 0; fin = 0; in_stall = 0; held = '0;
        sready_in_stall = 0;
        data_moved      = 0;
        @(posedge i_clk); #1; i_start = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b0;
        while (!fin && cyc < 300) begin
            i_dn_ready    = !(cyc >= rdy_at && cyc < rdy_at + rdy_len);
            i_remote_hold = (cyc >= hold_at && cyc < hold_at + hold_len);
            i_abort       = (!aborted && abort_at >= 0 && idx == abort_at && o_busy);
            if (idx < n && !(idx == gap_after && gap < gap_len)) begin
                s_valid = 1'b1; s_data = pay[idx]; s_last = (idx == n - 1);
            end else begin
                s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;
            end
            if (idx == gap_after && gap < gap_len && i_dn_ready) gap++;
            @(negedge i_clk);
            if (!i_dn_ready) begin
                if (s_ready) sready_in_stall = 1;
                if (!in_stall) held = o_data;
                else if (o_data !== held) data_moved = 1;
                in_stall = 1;
            end else begin
                in_stall = 0;
            end
            if (s_valid && s_ready) idx++;
            if (i_abort) aborted = 1;
            if (o_done || (aborted && !o_busy)) fin = 1;
            @(posedge i_clk); #1;
            cyc++;
        end
        i_abort = 0; s_valid = 0; s_last = 0; s_data = 32'h0; i_remote_hold = 0; i_dn_ready = 1;
        accepted = idx;
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timeout: frame did not complete, words accepted %0d of %0d", idx, n);
        end
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        n_tests++; if (o_data !== P_SYNC) begin n_fail++; $display("FAIL reset_data: got %h want %h", o_data, P_SYNC); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sready: got %b want 0", s_ready); end
        i_reset_n   = 1'b1;
        i_idle_prim = IDLE_A;
        @(posedge i_clk); #1;
        n_tests++; if (o_data !== IDLE_A) begin n_fail++; $display("FAIL idle_passthru: got %h want %h", o_data, IDLE_A); end
    endtask

    task automatic test_single_word();
        int base;
        int dbase;
        pay[0] = 32'h0000_0000;
        base = cap_q.size(); dbase = done_total;
        drive_frame(1, -1, 0, -1, 0, -1, 0, -1);
        extract(base, 4);
        build_expected(1);
        n_tests++; if (got_q[1] !== ZERO_W0) begin n_fail++; $display("FAIL single_first_mask: got %h want %h", got_q[1], ZERO_W0); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL single_word[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_tests++; if (cap_q[after_idx] !== IDLE_A) begin n_fail++; $display("FAIL single_idle_after: got %h want %h", cap_q[after_idx], IDLE_A); end
        n_tests++; if (done_total - dbase !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_total - dbase); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", o_busy); end
    endtask

    task automatic test_four_word_gap();
        int base;
        pay[0] = 32'h0123_4567; pay[1] = 32'h89ab_cdef; pay[2] = 32'hdead_beef; pay[3] = 32'h0000_0000;
        base = cap_q.size();
        drive_frame(4, -1, 0, -1, 0, -1, 0, -1);
        extract(base, 7);
        ref_q = got_q;
        build_expected(4);
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (ref_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL four_nostall[%0d]: got %h want %h", k, ref_q[k], exp_q[k]); end
        end
        base = cap_q.size();
        drive_frame(4, 2, 3, -1, 0, -1, 0, -1);
        extract(base, 7);
        n_tests++; if (hold_cnt !== 3) begin n_fail++; $display("FAIL gap_hold_count: got %0d want 3", hold_cnt); end
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL gap_word[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        for (int k = 3; k <= 4; k++) begin
            n_tests++;
            if (got_q[k] !== ref_q[k]) begin n_fail++; $display("FAIL gap_vs_nostall[%0d]: got %h want %h", k, got_q[k], ref_q[k]); end
        end
    endtask

    task automatic test_ready_stall();
        int base;
        pay[0] = 32'hcafe_f00d; pay[1] = 32'h1111_2222; pay[2] = 32'h3333_4444; pay[3] = 32'hffff_ffff;
        base = cap_q.size();
        drive_frame(4, -1, 0, 3, 5, -1, 0, -1);
        extract(base, 7);
        build_expected(4);
        n_tests++; if (sready_in_stall !== 1'b0) begin n_fail++; $display("FAIL stall_sready: got %b want 0", sready_in_stall); end
        n_tests++; if (data_moved !== 1'b0) begin n_fail++; $display("FAIL stall_data_held: got moved=%b want 0", data_moved); end
        n_tests++; if (hold_cnt !== 0) begin n_fail++; $display("FAIL stall_hold_count: got %0d want 0", hold_cnt); end
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL stall_word[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_abort();
        int base;
        int dbase;
        pay[0] = 32'haaaa_5555; pay[1] = 32'h5555_aaaa; pay[2] = 32'h1234_5678; pay[3] = 32'h8765_4321;
        base = cap_q.size(); dbase = done_total;
        drive_frame(4, -1, 0, -1, 0, -1, 0, 2);
        extract(base, 4);
        build_expected(4);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL abort_word[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
        end
        n_tests++; if (got_q[3] !== P_SYNC) begin n_fail++; $display("FAIL abort_sync: got %h want %h", got_q[3], P_SYNC); end
        n_tests++; if (done_total - dbase !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_total - dbase); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", o_busy); end
        n_tests++; if (accepted !== 2) begin n_fail++; $display("FAIL abort_accepted: got %0d want 2", accepted); end
        i_abort = 1'b1;
        @(posedge i_clk); #1;
        i_abort = 1'b0;
        n_tests++; if (o_data !== IDLE_A) begin n_fail++; $display("FAIL abort_idle_ignored: got %h want %h", o_data, IDLE_A); end
        pay[0] = 32'h0000_0000;
        base = cap_q.size();
        drive_frame(1, -1, 0, -1, 0, -1, 0, -1);
        extract(base, 4);
        build_expected(1);
        n_tests++; if (got_q[1] !== ZERO_W0) begin n_fail++; $display("FAIL abort_reseed: got %h want %h", got_q[1], ZERO_W0); end
        n_tests++; if (got_q[2] !== exp_q[2]) begin n_fail++; $display("FAIL abort_next_crc: got %h want %h", got_q[2], exp_q[2]); end
    endtask

    task automatic test_remote_hold();
        int base;
        pay[0] = 32'h0f0f_0f0f; pay[1] = 32'hf0f0_f0f0; pay[2] = 32'h7777_8888; pay[3] = 32'h9999_0000;
        base = cap_q.size();
        drive_frame(4, -1, 0, -1, 0, 2, 4, -1);
        extract(base, 7);
        build_expected(4);
`ifdef SATALNK_TXHOLD_EN
        n_tests++; if (holda_cnt !== 4) begin n_fail++; $display("FAIL holda_count: got %0d want 4", holda_cnt); end
`else
        n_tests++; if (holda_cnt !== 0) begin n_fail++; $display("FAIL holda_count: got %0d want 0", holda_cnt); end
`endif
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL holda_word[%0d]: got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid_crc();
        s_valid = 1'b1; s_data = 32'h0; s_last = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        n_tests++; if (o_data !== ZERO_W0) begin n_fail++; $display("FAIL midcrc_pre_data: got %h want %h", o_data, ZERO_W0); end
        n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midcrc_pre_busy: got %b want 1", o_busy); end
        #1;
        i_reset_n = 1'b0;
        #1;
        n_tests++; if (o_data !== P_SYNC) begin n_fail++; $display("FAIL midcrc_reset_data: got %h want %h", o_data, P_SYNC); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL midcrc_reset_busy: got %b want 0", o_busy); end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_start       = 1'b0;
        i_abort       = 1'b0;
        i_idle_prim   = P_SYNC;
        i_remote_hold = 1'b0;
        s_valid       = 1'b0;
        s_data        = 32'h0;
        s_last        = 1'b0;
        i_dn_ready    = 1'b1;
        test_reset();
        test_single_word();
        test_four_word_gap();
        test_ready_stall();
        test_abort();
        test_remote_hold();
        test_reset_mid_crc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
